// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the shared ALU and the arbiter that sequences it.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [3:0]         req_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [1:0]         alu_op;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;
    logic               rsp_valid;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic [3:0]         rsp_flags;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_flags,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_flags,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one slow ripple ALU between two requesters; operands are
// held in registers for SETTLE_CYCLES clocks before the result and flags are captured.
module alu_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_grant_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg, rsp_result_reg;
    logic [1:0]       alu_op_reg;
    logic [3:0]       rsp_flags_reg;
    logic             rsp_id_reg;

    logic             grant_id;
    logic [1:0]       grant_vec;
    logic             accept;

    logic [WIDTH-1:0] a_slice [2];
    logic [WIDTH-1:0] b_slice [2];
    logic [1:0]       op_slice [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign a_slice[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
            assign op_slice[gi] = bus.req_op[2*gi +: 2];
        end
    endgenerate

    // With both pending, the requester not served last wins; otherwise the lone one.
    always_comb begin
        state_next = state_reg;
        grant_vec  = 2'b00;
        accept     = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = bus.req_valid[1];
        end
        case (state_reg)
            IDLE: begin
                if ((bus.req_valid != 2'b00) && !reset) begin
                    grant_vec[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_next          = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            rsp_id_reg     <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_reg      <= a_slice[grant_id];
                alu_b_reg      <= b_slice[grant_id];
                alu_op_reg     <= op_slice[grant_id];
                owner_reg      <= grant_id;
                last_grant_reg <= grant_id;
                cnt_reg        <= CNT_LOAD;
            end else if (state_reg == SETTLE) begin
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end else begin
                    // Inputs have now been stable for SETTLE_CYCLES full cycles.
                    rsp_result_reg <= bus.alu_result;
                    rsp_flags_reg  <= bus.alu_flags;
                    rsp_id_reg     <= owner_reg;
                end
            end
        end
    end

    assign bus.req_ready  = grant_vec;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_op     = alu_op_reg;
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_flags  = rsp_flags_reg;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a SETTLE_CYCLES=4 and a SETTLE_CYCLES=1 instance, each with a
// behavioural ALU and a scoreboard filled at accept and drained at rsp_valid.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) if4 ();
    alu_arbiter_if #(.WIDTH(32)) if1 ();

    alu_arbiter #(.WIDTH(32), .SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    alu_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    // Returns {CarryOut, Zero, Overflow, negative, result}.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [32:0] full;
        logic [31:0] r;
        logic        c, v;
        full = '0;
        case (op)
            2'b10: begin
                full = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = full[31:0]; c = full[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b00: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[31:0]; c = full[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01:   begin r = a & b; c = 1'b0; v = 1'b0; end
            default: begin r = a | b; c = 1'b0; v = 1'b0; end
        endcase
        return {c, (r == 32'd0), v, r[31], r};
    endfunction

    logic [35:0] alu4_out, alu1_out;
    logic        ovr1 = 1'b0;
    logic [31:0] ovr_result = '0;
    logic [3:0]  ovr_flags = '0;
    assign alu4_out       = alu_model(if4.alu_a, if4.alu_b, if4.alu_op);
    assign alu1_out       = alu_model(if1.alu_a, if1.alu_b, if1.alu_op);
    assign if4.alu_result = alu4_out[31:0];
    assign if4.alu_flags  = alu4_out[35:32];
    assign if1.alu_result = ovr1 ? ovr_result : alu1_out[31:0];
    assign if1.alu_flags  = ovr1 ? ovr_flags : alu1_out[35:32];

    // Scoreboards: {id, flags, result}
    logic [36:0] sb4[$];
    logic [36:0] sb1[$];
    int          rsp4_cnt = 0;
    int          rsp1_cnt = 0;
    logic        m_id;
    logic [36:0] m_exp;

    always @(negedge clk) begin
        if (if4.rsp_valid) begin
            rsp4_cnt++;
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL rsp4_unexpected: got id=%0d result=%0h, required no response",
                         if4.rsp_id, if4.rsp_result);
            end else begin
                m_exp = sb4.pop_front();
                if ({if4.rsp_id, if4.rsp_flags, if4.rsp_result} !== m_exp) begin
                    errors++;
                    $display("FAIL rsp4_data: got %0h, required %0h",
                             {if4.rsp_id, if4.rsp_flags, if4.rsp_result}, m_exp);
                end
            end
        end
        if (!reset && (if4.req_valid & if4.req_ready) != 2'b00) begin
            m_id = if4.req_ready[1];
            sb4.push_back({m_id, alu_model(m_id ? if4.req_a[63:32] : if4.req_a[31:0],
                                           m_id ? if4.req_b[63:32] : if4.req_b[31:0],
                                           m_id ? if4.req_op[3:2] : if4.req_op[1:0])});
        end
    end

    always @(negedge clk) begin
        if (if1.rsp_valid) begin
            rsp1_cnt++;
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected: got id=%0d result=%0h, required no response",
                         if1.rsp_id, if1.rsp_result);
            end else begin
                m_exp = sb1.pop_front();
                if ({if1.rsp_id, if1.rsp_flags, if1.rsp_result} !== m_exp) begin
                    errors++;
                    $display("FAIL rsp1_data: got %0h, required %0h",
                             {if1.rsp_id, if1.rsp_flags, if1.rsp_result}, m_exp);
                end
            end
        end
        if (!reset && ovr1 == 1'b0 && (if1.req_valid & if1.req_ready) != 2'b00) begin
            m_id = if1.req_ready[1];
            sb1.push_back({m_id, alu_model(m_id ? if1.req_a[63:32] : if1.req_a[31:0],
                                           m_id ? if1.req_b[63:32] : if1.req_b[31:0],
                                           m_id ? if1.req_op[3:2] : if1.req_op[1:0])});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if4.req_valid = 2'b11; if1.req_valid = 2'b11;
        if4.req_a = {32'd11, 32'd22}; if4.req_b = {32'd1, 32'd2}; if4.req_op = 4'b1010;
        reset = 1'b1;
        step(); step(); step();
        checks++;
        if (if4.req_ready !== 2'b00 || if1.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 00/00", if4.req_ready, if1.req_ready);
        end
        checks++;
        if ({if4.busy, if4.rsp_valid, if4.alu_a, if4.alu_b, if4.alu_op, if4.rsp_result,
             if4.rsp_flags, if4.rsp_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b alu_a=%0h rsp_result=%0h, required all 0",
                     if4.busy, if4.alu_a, if4.rsp_result);
        end
        if4.req_valid = 2'b00; if1.req_valid = 2'b00;
        reset = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        int rsp_at = -1;
        if4.req_a[31:0] = 32'd5; if4.req_b[31:0] = 32'd3; if4.req_op[1:0] = 2'b10;
        if4.req_valid = 2'b01;
        #1;
        checks++;
        if (if4.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b, required 01", if4.req_ready);
        end
        step();
        if4.req_valid = 2'b00;
        checks++;
        if (if4.alu_a !== 32'd5 || if4.alu_b !== 32'd3 || if4.alu_op !== 2'b10 || if4.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_alu_regs: got a=%0d b=%0d op=%b ready=%b, required 5 3 10 00",
                     if4.alu_a, if4.alu_b, if4.alu_op, if4.req_ready);
        end
        for (int j = 0; j < 8; j++) begin
            if (if4.busy) busy_cnt++;
            if (if4.rsp_valid) begin
                rsp_at = j;
                checks++;
                if (if4.rsp_result !== 32'd2 || if4.rsp_id !== 1'b0 || if4.rsp_flags[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_rsp: got result=%0d id=%0d zero=%b, required 2 0 0",
                             if4.rsp_result, if4.rsp_id, if4.rsp_flags[2]);
                end
            end
            step();
        end
        checks++;
        if (rsp_at != 4) begin
            errors++;
            $display("FAIL single_latency: got rsp_valid at %0d, required 4 cycles after accept edge", rsp_at);
        end
        checks++;
        if (busy_cnt != 5) begin
            errors++;
            $display("FAIL single_busy: got %0d busy cycles, required 5", busy_cnt);
        end
        $display("test_single done: rsp_at=%0d busy=%0d", rsp_at, busy_cnt);
    endtask

    task automatic test_alternation();
        int n = 0;
        logic ids [3];
        int at [3];
        reset = 1'b1; step(); reset = 1'b0;
        if4.req_a = {32'd50, 32'd100}; if4.req_b = {32'd60, 32'd1}; if4.req_op = 4'b1010;
        if4.req_valid = 2'b11;
        for (int c = 0; c < 60 && n < 3; c++) begin
            #1;
            if (if4.req_ready != 2'b00) begin
                ids[n] = if4.req_ready[1];
                at[n] = c;
                n++;
            end
            step();
        end
        if4.req_valid = 2'b00;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL alt_count: got %0d accepts, required 3", n);
        end else begin
            checks++;
            if (ids[0] !== 1'b0 || ids[1] !== 1'b1 || ids[2] !== 1'b0) begin
                errors++;
                $display("FAIL alt_order: got %0d,%0d,%0d, required 0,1,0", ids[0], ids[1], ids[2]);
            end
            checks++;
            if (at[1] - at[0] != 6 || at[2] - at[1] != 6) begin
                errors++;
                $display("FAIL alt_spacing: got %0d,%0d, required 6,6", at[1] - at[0], at[2] - at[1]);
            end
        end
        for (int i = 0; i < 50 && if4.busy; i++) step();
        checks++;
        if (if4.busy) begin
            errors++;
            $display("FAIL alt_drain: got busy=1 after timeout, required 0");
        end
        $display("test_alternation done: accepts=%0d", n);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3] = '{32'd1000, 32'd7, 32'h0000F0F0};
        logic [31:0] tb [3] = '{32'd1, 32'd7, 32'h00000FF0};
        logic [1:0]  top [3] = '{2'b00, 2'b10, 2'b01};
        int base = rsp4_cnt;
        logic got;
        if4.req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            if4.req_a[63:32] = ta[k]; if4.req_b[63:32] = tb[k]; if4.req_op[3:2] = top[k];
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                #1;
                if (if4.req_ready == 2'b10) got = 1'b1;
                else step();
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL b2b_accept%0d: got no req_ready[1], required accept", k);
            end
            step();
        end
        if4.req_valid = 2'b00;
        for (int i = 0; i < 50 && if4.busy; i++) step();
        checks++;
        if (rsp4_cnt - base != 3 || if4.rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rsp: got %0d responses last id %0d, required 3 id 1", rsp4_cnt - base, if4.rsp_id);
        end
        $display("test_back_to_back done: responses=%0d", rsp4_cnt - base);
    endtask

    task automatic test_reset_midop();
        int base;
        if4.req_a[31:0] = 32'd9; if4.req_b[31:0] = 32'd4; if4.req_op[1:0] = 2'b10;
        if4.req_valid = 2'b01;
        for (int t = 0; t < 20 && if4.req_ready != 2'b01; t++) step();
        step();
        step();
        // Now in the second SETTLE cycle; a new request is already pending.
        reset = 1'b1;
        if4.req_a[31:0] = 32'd20; if4.req_b[31:0] = 32'd7;
        #1;
        checks++;
        if (if4.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL midop_ready_in_reset: got %b, required 00", if4.req_ready);
        end
        step();
        reset = 1'b0;
        sb4.delete();
        base = rsp4_cnt;
        checks++;
        if ({if4.busy, if4.rsp_valid, if4.alu_a, if4.alu_b, if4.alu_op, if4.rsp_result,
             if4.rsp_flags, if4.rsp_id} !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got busy=%b alu_a=%0h rsp_result=%0h, required all 0",
                     if4.busy, if4.alu_a, if4.rsp_result);
        end
        #1;
        checks++;
        if (if4.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midop_reaccept: got %b, required 01", if4.req_ready);
        end
        step();
        if4.req_valid = 2'b00;
        for (int i = 0; i < 50 && if4.busy; i++) step();
        checks++;
        if (rsp4_cnt - base != 1 || if4.rsp_result !== 32'd13) begin
            errors++;
            $display("FAIL midop_single_rsp: got %0d responses result %0d, required 1 result 13",
                     rsp4_cnt - base, if4.rsp_result);
        end
        $display("test_reset_midop done");
    endtask

    task automatic test_settle1();
        int rsp_at = -1;
        if1.req_a[31:0] = 32'h7FFFFFFF; if1.req_b[31:0] = 32'h7FFFFFFF; if1.req_op[1:0] = 2'b10;
        if1.req_valid = 2'b01;
        #1;
        checks++;
        if (if1.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL s1_ready: got %b, required 01", if1.req_ready);
        end
        step();
        if1.req_valid = 2'b00;
        for (int j = 0; j < 5; j++) begin
            if (if1.rsp_valid) begin
                rsp_at = j;
                checks++;
                if (if1.rsp_result !== 32'd0 || if1.rsp_flags[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL s1_rsp: got result=%0h zero=%b, required 0 1", if1.rsp_result, if1.rsp_flags[2]);
                end
            end
            step();
        end
        checks++;
        if (rsp_at != 1) begin
            errors++;
            $display("FAIL s1_latency: got rsp_valid at %0d, required 1 cycle after accept edge", rsp_at);
        end
        $display("test_settle1 done: rsp_at=%0d", rsp_at);
    endtask

    task automatic test_flag_hold();
        logic got = 1'b0;
        ovr1 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            ovr_result = $urandom;
            ovr_flags = 4'($urandom);
            step();
            checks++;
            if (if1.rsp_result !== 32'd0 || if1.rsp_flags !== 4'b1100) begin
                errors++;
                $display("FAIL hold_rsp: got result=%0h flags=%b, required 0 1100", if1.rsp_result, if1.rsp_flags);
            end
        end
        ovr1 = 1'b0;
        if1.req_a[63:32] = 32'd10; if1.req_b[63:32] = 32'd3; if1.req_op[3:2] = 2'b10;
        if1.req_valid = 2'b10;
        for (int t = 0; t < 20 && !got; t++) begin
            #1;
            if (if1.req_ready == 2'b10) got = 1'b1;
            else step();
        end
        step();
        if1.req_valid = 2'b00;
        for (int i = 0; i < 20 && if1.busy; i++) step();
        checks++;
        if (!got || if1.rsp_result !== 32'd7 || if1.rsp_id !== 1'b1 || if1.rsp_flags !== 4'b1000) begin
            errors++;
            $display("FAIL hold_recapture: got result=%0d id=%0d flags=%b, required 7 1 1000",
                     if1.rsp_result, if1.rsp_id, if1.rsp_flags);
        end
        $display("test_flag_hold done");
    endtask

    initial begin
        if4.req_valid = '0; if4.req_a = '0; if4.req_b = '0; if4.req_op = '0;
        if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.req_op = '0;
        test_reset();
        test_single();
        test_alternation();
        test_back_to_back();
        test_reset_midop();
        test_settle1();
        test_flag_hold();
        step();
        checks++;
        if (sb4.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d/%0d pending, required 0/0", sb4.size(), sb1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
